// File: rtl/char_uart_tx.sv
// Buffers an 8-bit character stream in a small synchronous FIFO and sends each
// character as an 8N1 UART frame, LSB first, at CLKS_PER_BIT clocks per bit.
module char_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  letter,
  input  logic                        letter_valid,
  output logic                        letter_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;
  logic          push, pop;

  // Serializer state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_c, busy_c, bit_end;

  // Ready looks only at the registered count, so a full FIFO refuses a push
  // even in a cycle where the serializer pops.
  assign letter_ready = (count_q != CW'(FIFO_DEPTH));
  assign push         = letter_valid && letter_ready;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign tx           = tx_c;
  assign busy         = busy_c;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (letter_valid && !letter_ready) overflow_q <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; entries are only meaningful between
  // the pointers, which do reset, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= letter;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  assign bit_end = (bit_cnt_q == CNT_MAX);

  // NOTE: every signal driven here gets a default first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    tx_c      = 1'b1;
    busy_c    = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        busy_c    = 1'b0;
        bit_cnt_d = '0;
        bit_idx_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        tx_c = 1'b0;
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        tx_c = shift_q[0];
        if (bit_end) begin
          bit_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          // Chain straight into the next frame when data is waiting.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/char_uart_tx.md
Name: char_uart_tx

Overview:
- Downstream consumer of the character generator's 8-bit letter stream.
- Buffers incoming characters in a small synchronous FIFO.
- Serializes each character onto a single UART line, 8N1 format, LSB first, at a fixed clocks-per-bit rate.
- Lets the generator emit one character per clock while the slow serial line drains them.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per UART bit; legal values are 1 and above.
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- letter  in  8  character byte from upstream.
- letter_valid  in  1  letter is valid this cycle.
- letter_ready  out  1  FIFO can accept; equals !full (combinational from count).
- tx  out  1  UART serial output; idle level is 1.
- busy  out  1  high while a frame is being transmitted (START, DATA, STOP).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of entries held.
- overflow  out  1  sticky; set when letter_valid=1 and letter_ready=0.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - tx=1, busy=0, fifo_count=0, overflow=0, letter_ready=1.
  - FSM goes to IDLE; FIFO pointers clear.
  - An in-flight frame is aborted; tx=1 from the next edge.
  - Reset overrides all simultaneous push/pop.
- FIFO:
  - Push on a clk edge when letter_valid && letter_ready.
  - Pop is issued only by the FSM.
  - letter_ready depends on the current count only. When full, a push is rejected even if a pop occurs in the same cycle.
  - Simultaneous push and pop with 0 < count < FIFO_DEPTH leaves the count unchanged and keeps data order.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow: a rejected valid beat drops the byte and sets overflow=1. It stays set until reset.
- FSM states: IDLE, START, DATA, STOP. Each bit period is one bit counter (0..CLKS_PER_BIT-1) plus a bit index (0..7).
  - IDLE: tx=1, busy=0. If count>0: pop the head into the shift register, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right. After index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if count>0, pop and go directly to START (no idle gap); else go to IDLE.
  - busy=1 in START, DATA and STOP.
- Latency:
  - A byte pushed into an empty FIFO in IDLE at edge N is popped at edge N+1.
  - tx goes low after edge N+1.
  - A frame lasts exactly 10*CLKS_PER_BIT cycles.
- CLKS_PER_BIT=1: each state advances every cycle; the frame is 10 cycles.
- An empty FIFO at the end of STOP returns the FSM to IDLE with tx=1 continuously.

Test Plan:
- Single byte: CLKS_PER_BIT=4, push 0x48 ('H') once into an idle block.
  - tx low starting one cycle after the push, for 4 cycles.
  - Data bits 0,0,0,1,0,0,1,0, each 4 cycles.
  - Stop 1 for 4 cycles; busy high for 40 cycles; then IDLE.
- Burst: push "Hello, World!" (13 bytes) on 13 consecutive cycles.
  - All 13 accepted; overflow=0; peak fifo_count=12.
  - 13 frames back to back with no idle gap; decoded stream equals the input string.
- Overflow: push 20 bytes on consecutive cycles (edges 0..19).
  - Edges 0..16 accepted; fifo_count=16 after edge 16; letter_ready=0.
  - Edges 17..19 dropped; overflow=1.
  - The 17 accepted bytes are transmitted in order.
- Full with pop: hold the FIFO at 16 with letter_valid=1 across the STOP-end pop.
  - The push in the pop cycle is rejected (count 16→15).
  - The next cycle's push is accepted (15→16).
  - overflow is set.
- Reset mid-frame: assert reset for 1 cycle during DATA bit 3.
  - Next edge: tx=1, busy=0, fifo_count=0, overflow=0.
  - No further frames until a new push; the next push transmits a clean full frame.
- CLKS_PER_BIT=1: push 0xA5.
  - tx sequence over 10 cycles: 0,1,0,1,0,0,1,0,1,1.
